signal_display_ctrl: RTL and testbench
======================================

SIGNAL_DISPLAY_CTRL -- requirements
Module: signal_display_ctrl

Interface
REQ-001 Parameter RED_SEC, default 10, vehicle-red/ped-green phase length in seconds; legal range 1..99.
REQ-002 Parameter YELLOW_SEC, default 1, vehicle-yellow phase length in seconds; legal range 1..99.
REQ-003 Parameter GREEN_SEC, default 10, vehicle-green phase length in seconds; legal range 1..99.
REQ-004 Parameter PED_FLASH_SEC, default 3, length of the ped-green flash window in seconds; legal range 0..RED_SEC.
REQ-005 Port clk_1Hz, input, 1 bit: 1 Hz system clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port traf_state, input, 3 bits: one-hot vehicle phase from the controller; 001 red, 010 yellow, 100 green.
REQ-008 Port ped_state, input, 2 bits: pedestrian phase from the controller; 01 green, 10 red.
REQ-009 Ports lamp_red, lamp_yellow and lamp_green, outputs, 1 bit each: vehicle lamp drives.
REQ-010 Ports ped_lamp_red and ped_lamp_green, outputs, 1 bit each: pedestrian lamp drives.
REQ-011 Ports cnt_tens and cnt_ones, outputs, 4 bits each: BCD seconds remaining in the current phase.
REQ-012 Port cnt_valid, output, 1 bit: high when cnt_tens and cnt_ones hold a meaningful value.
REQ-013 Port fault, output, 1 bit: high while the block is in the FAULT state.

Function
REQ-014 Every output SHALL be a register; each output reflects the inputs sampled at the previous rising edge, giving one-cycle latency.
REQ-015 A legal input pair SHALL be one of exactly three combinations: {001,01}, {010,10} or {100,10}; every other combination is illegal.
REQ-016 Phase entry SHALL occur when a legal pair differs from the last accepted phase.
  - On entry, the 7-bit remaining counter loads RED_SEC, YELLOW_SEC or GREEN_SEC for the new phase.
  - On every other RUN cycle, remaining decrements by 1 and saturates at 0.
REQ-017 cnt_tens and cnt_ones SHALL be the BCD form of remaining; cnt_valid SHALL be 1 in RUN and 0 in FAULT.
REQ-018 In RUN, exactly one vehicle lamp SHALL be lit, matching the accepted phase; ped_lamp_red and ped_lamp_green SHALL match ped_state.
REQ-019 The control FSM SHALL have two states, RUN and FAULT, and SHALL track consecutive illegal and consecutive legal samples.
  - RUN to FAULT: on the 2nd consecutive illegal sample.
  - A single illegal sample in RUN holds all outputs and remaining unchanged (glitch filter).
  - FAULT to RUN: on the 3rd consecutive legal sample, which is treated as a phase entry.
  - Any illegal sample in FAULT restarts the legal-sample count.
REQ-020 In FAULT, outputs SHALL be as follows:
  - lamp_yellow toggles every cycle, starting at 1.
  - lamp_red, lamp_green and ped_lamp_green are 0; ped_lamp_red is 1.
  - cnt_tens and cnt_ones are 0; fault is 1.
REQ-021 If rst_n asserts mid-phase, the block SHALL abandon the phase; the first legal sample after release is a phase entry.

Reset
REQ-022 While rst_n is low, the block SHALL hold these values:
  - lamp_red = 1 and ped_lamp_red = 1; all other lamps 0.
  - cnt_tens, cnt_ones, cnt_valid and fault all 0.
  - FSM in RUN, last accepted phase = none (000), both sample counters 0.
  - Blink phase cleared.

Configuration
REQ-023 When macro PED_FLASH_EN is defined, ped_lamp_green SHALL flash during the ped-green phase.
  - The flash window is 1 <= remaining <= PED_FLASH_SEC.
  - Within the window, ped_lamp_green toggles every cycle, and the first window cycle is 0.
  - When remaining = 0, ped_lamp_green is steady 1.
REQ-024 When PED_FLASH_EN is undefined, ped_lamp_green SHALL be steady during ped green, and PED_FLASH_SEC SHALL have no effect.

Structure
REQ-025 Shared package signal_pkg SHALL hold the following:
  - Phase encodings TRAF_RED=3'b001, TRAF_YELLOW=3'b010, TRAF_GREEN=3'b100.
  - Pedestrian encodings PED_GREEN=2'b01, PED_RED=2'b10.
  - The FSM state enum (RUN, FAULT).
  - The constants FAULT_ENTER_CNT=2 and FAULT_EXIT_CNT=3.
REQ-026 One combinational sub-module, bcd_split, SHALL convert a binary value 0..99 into two BCD digits; the top level SHALL instantiate it once.

Verification
REQ-027 Reset release, then {001,01} held for 12 cycles -> lamp_red=1, ped_lamp_green=1; count sequence 10,9,...,1,0,0; cnt_valid=1.
REQ-028 Transition {001,01} to {010,10} to {100,10} -> one cycle after each change, the matching lamp is lit and the count shows 1, then 10.
REQ-029 With PED_FLASH_EN and default parameters, during red -> ped_lamp_green=1 at counts 10..4, pattern 0,1,0 at counts 3,2,1, and 1 at count 0.
REQ-030 A single {011,10} sample mid-green -> outputs frozen for one cycle, fault stays 0, countdown resumes from the held value.
REQ-031 Two {000,00} samples -> fault=1, lamp_yellow toggles 1,0,1..., cnt_valid=0; after 3 legal {001,01} samples -> RUN with count 10.
REQ-032 Assert rst_n mid-green with count at 6 -> immediate reset values; after release with {100,10} held -> count reloads to 10.

Source files
------------

// File: rtl/signal_pkg.sv
// Shared definitions for the signal display controller.
//   - Vehicle phase encodings (one-hot) and pedestrian phase encodings.
//   - Control FSM state type (RUN / FAULT).
//   - Consecutive-sample thresholds for entering and leaving FAULT.
//   - is_legal(): true only for the three accepted {traf, ped} combinations.
package signal_pkg;

  localparam logic [2:0] TRAF_NONE   = 3'b000;
  localparam logic [2:0] TRAF_RED    = 3'b001;
  localparam logic [2:0] TRAF_YELLOW = 3'b010;
  localparam logic [2:0] TRAF_GREEN  = 3'b100;

  localparam logic [1:0] PED_GREEN = 2'b01;
  localparam logic [1:0] PED_RED   = 2'b10;

  typedef enum logic [0:0] {
    RUN,
    FAULT
  } ctrl_state_e;

  // Consecutive illegal samples that force FAULT, and consecutive legal
  // samples that release it.
  localparam int unsigned FAULT_ENTER_CNT = 2;
  localparam int unsigned FAULT_EXIT_CNT  = 3;

  function automatic logic is_legal(logic [2:0] traf, logic [1:0] ped);
    return ((traf == TRAF_RED)    && (ped == PED_GREEN)) ||
           ((traf == TRAF_YELLOW) && (ped == PED_RED))   ||
           ((traf == TRAF_GREEN)  && (ped == PED_RED));
  endfunction

endpackage

// File: rtl/bcd_split.sv
// Combinational binary-to-BCD split for values 0..99.
// Ports:
//   bin  - 7-bit binary value, expected range 0..99
//   tens - BCD tens digit (saturates at 9 for out-of-range input)
//   ones - BCD ones digit
module bcd_split (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 4'd0;
    for (int unsigned i = 1; i <= 9; i++) begin
      if (bin >= 7'(10 * i)) begin
        tens = 4'(i);
      end
    end
    // bin - 10*tens is 0..9, so the low nibble of the difference is exact.
    ones = bin[3:0] - (tens * 4'd10);
  end

endmodule

// File: rtl/signal_display_ctrl.sv
// Signal display controller: turns the controller's vehicle/pedestrian phase
// into registered lamp drives and a BCD countdown of seconds left in the phase.
// Illegal phase pairs are glitch-filtered; a sustained illegal input drives a
// FAULT mode (flashing yellow, pedestrians held on red) until the input has
// been legal for several consecutive samples.
//
// Optional feature macro: PED_FLASH_EN -- when defined, the pedestrian green
// lamp flashes during the last PED_FLASH_SEC seconds of the pedestrian phase.
//
// Ports:
//   clk_1Hz        - 1 Hz clock, all state changes on rising edge
//   rst_n          - asynchronous active-low reset
//   traf_state     - one-hot vehicle phase (001 red, 010 yellow, 100 green)
//   ped_state      - pedestrian phase (01 green, 10 red)
//   lamp_red/yellow/green     - vehicle lamp drives
//   ped_lamp_red/ped_lamp_green - pedestrian lamp drives
//   cnt_tens/cnt_ones - BCD seconds remaining
//   cnt_valid      - count digits are meaningful
//   fault          - block is in FAULT
module signal_display_ctrl
  import signal_pkg::*;
#(
  parameter int unsigned RED_SEC       = 10,
  parameter int unsigned YELLOW_SEC    = 1,
  parameter int unsigned GREEN_SEC     = 10,
  parameter int unsigned PED_FLASH_SEC = 3
) (
  input  logic       clk_1Hz,
  input  logic       rst_n,
  input  logic [2:0] traf_state,
  input  logic [1:0] ped_state,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       ped_lamp_red,
  output logic       ped_lamp_green,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       cnt_valid,
  output logic       fault
);

  // How the output registers are updated this cycle.
  typedef enum logic [1:0] {
    OutHold,
    OutRun,
    OutFaultEnter,
    OutFault
  } out_sel_e;

  ctrl_state_e state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [6:0]  remaining_q, remaining_d;
  logic [1:0]  ill_cnt_q, ill_cnt_d;
  logic [1:0]  leg_cnt_q, leg_cnt_d;
  out_sel_e    out_sel;
  logic        legal;

  logic        red_q, red_d;
  logic        yellow_q, yellow_d;
  logic        green_q, green_d;
  logic        ped_red_q, ped_red_d;
  logic        ped_green_q, ped_green_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;

`ifdef PED_FLASH_EN
  // Set when the previous output cycle was inside the ped-green flash window.
  logic        flash_q, flash_d;
`endif

  function automatic logic [6:0] phase_secs(logic [2:0] traf);
    case (traf)
      TRAF_RED:    return 7'(RED_SEC);
      TRAF_YELLOW: return 7'(YELLOW_SEC);
      default:     return 7'(GREEN_SEC);
    endcase
  endfunction

  always_comb legal = is_legal(traf_state, ped_state);

  // Control FSM: next state, sample counters and countdown.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    ill_cnt_d   = ill_cnt_q;
    leg_cnt_d   = leg_cnt_q;
    out_sel     = OutHold;
    unique case (state_q)
      RUN: begin
        if (legal) begin
          ill_cnt_d = '0;
          out_sel   = OutRun;
          if (traf_state != phase_q) begin
            phase_d     = traf_state;
            remaining_d = phase_secs(traf_state);
          end else if (remaining_q != 7'd0) begin
            remaining_d = remaining_q - 7'd1;
          end
        end else if (32'(ill_cnt_q) + 32'd1 >= FAULT_ENTER_CNT) begin
          state_d   = FAULT;
          ill_cnt_d = '0;
          leg_cnt_d = '0;
          out_sel   = OutFaultEnter;
        end else begin
          // Single bad sample: everything else holds.
          ill_cnt_d = ill_cnt_q + 2'd1;
        end
      end
      FAULT: begin
        out_sel = OutFault;
        if (legal) begin
          if (32'(leg_cnt_q) + 32'd1 >= FAULT_EXIT_CNT) begin
            // Recovery is always a fresh phase entry.
            state_d     = RUN;
            leg_cnt_d   = '0;
            phase_d     = traf_state;
            remaining_d = phase_secs(traf_state);
            out_sel     = OutRun;
          end else begin
            leg_cnt_d = leg_cnt_q + 2'd1;
          end
        end else begin
          leg_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  bcd_split u_bcd_split (
    .bin  (remaining_d),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

  // Output next-state.
  always_comb begin
    red_d       = red_q;
    yellow_d    = yellow_q;
    green_d     = green_q;
    ped_red_d   = ped_red_q;
    ped_green_d = ped_green_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
`ifdef PED_FLASH_EN
    flash_d     = flash_q;
`endif
    unique case (out_sel)
      OutRun: begin
        red_d       = traf_state[0];
        yellow_d    = traf_state[1];
        green_d     = traf_state[2];
        ped_red_d   = ped_state[1];
        ped_green_d = ped_state[0];
        tens_d      = bcd_tens;
        ones_d      = bcd_ones;
        valid_d     = 1'b1;
        fault_d     = 1'b0;
`ifdef PED_FLASH_EN
        flash_d     = 1'b0;
        if ((ped_state == PED_GREEN) && (remaining_d != 7'd0) &&
            (32'(remaining_d) <= PED_FLASH_SEC)) begin
          // First window cycle dark, then toggle.
          ped_green_d = flash_q ? ~ped_green_q : 1'b0;
          flash_d     = 1'b1;
        end
`endif
      end
      OutFaultEnter, OutFault: begin
        red_d       = 1'b0;
        yellow_d    = (out_sel == OutFaultEnter) ? 1'b1 : ~yellow_q;
        green_d     = 1'b0;
        ped_red_d   = 1'b1;
        ped_green_d = 1'b0;
        tens_d      = 4'd0;
        ones_d      = 4'd0;
        valid_d     = 1'b0;
        fault_d     = 1'b1;
`ifdef PED_FLASH_EN
        flash_d     = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      phase_q     <= TRAF_NONE;
      remaining_q <= 7'd0;
      ill_cnt_q   <= '0;
      leg_cnt_q   <= '0;
      red_q       <= 1'b1;
      yellow_q    <= 1'b0;
      green_q     <= 1'b0;
      ped_red_q   <= 1'b1;
      ped_green_q <= 1'b0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      ill_cnt_q   <= ill_cnt_d;
      leg_cnt_q   <= leg_cnt_d;
      red_q       <= red_d;
      yellow_q    <= yellow_d;
      green_q     <= green_d;
      ped_red_q   <= ped_red_d;
      ped_green_q <= ped_green_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

`ifdef PED_FLASH_EN
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      flash_q <= 1'b0;
    end else begin
      flash_q <= flash_d;
    end
  end
`endif

  // Parameter legality; simulation-only check, no hardware.
  always_ff @(posedge clk_1Hz) begin
    assert ((RED_SEC >= 1) && (RED_SEC <= 99) && (YELLOW_SEC >= 1) && (YELLOW_SEC <= 99) &&
            (GREEN_SEC >= 1) && (GREEN_SEC <= 99) && (PED_FLASH_SEC <= RED_SEC));
  end

  assign lamp_red       = red_q;
  assign lamp_yellow    = yellow_q;
  assign lamp_green     = green_q;
  assign ped_lamp_red   = ped_red_q;
  assign ped_lamp_green = ped_green_q;
  assign cnt_tens       = tens_q;
  assign cnt_ones       = ones_q;
  assign cnt_valid      = valid_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_signal_display_ctrl.sv
module tb_signal_display_ctrl;

  localparam int RED = 10;
  localparam int YEL = 1;
  localparam int GRN = 10;
  localparam int PFS = 3;

  logic       clk_1Hz = 1'b0;
  logic       rst_n;
  logic [2:0] traf_state;
  logic [1:0] ped_state;
  logic       lamp_red, lamp_yellow, lamp_green, ped_lamp_red, ped_lamp_green;
  logic [3:0] cnt_tens, cnt_ones;
  logic       cnt_valid, fault;

  always #5 clk_1Hz = ~clk_1Hz;

  signal_display_ctrl #(
    .RED_SEC       (RED),
    .YELLOW_SEC    (YEL),
    .GREEN_SEC     (GRN),
    .PED_FLASH_SEC (PFS)
  ) dut (
    .clk_1Hz        (clk_1Hz),
    .rst_n          (rst_n),
    .traf_state     (traf_state),
    .ped_state      (ped_state),
    .lamp_red       (lamp_red),
    .lamp_yellow    (lamp_yellow),
    .lamp_green     (lamp_green),
    .ped_lamp_red   (ped_lamp_red),
    .ped_lamp_green (ped_lamp_green),
    .cnt_tens       (cnt_tens),
    .cnt_ones       (cnt_ones),
    .cnt_valid      (cnt_valid),
    .fault          (fault)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: phase 0 none, 1 red, 2 yellow, 3 green.
  bit m_fault;
  int m_phase, m_rem, m_ill, m_leg, m_win;
  bit e_red, e_yel, e_grn, e_pr, e_pg, e_valid, e_fault;
  int e_cnt;

  function automatic int pair_phase(logic [2:0] t, logic [1:0] p);
    if (t == 3'b001 && p == 2'b01) return 1;
    if (t == 3'b010 && p == 2'b10) return 2;
    if (t == 3'b100 && p == 2'b10) return 3;
    return 0;
  endfunction

  function automatic int secs(int ph);
    return (ph == 1) ? RED : (ph == 2) ? YEL : GRN;
  endfunction

  function automatic logic [7:0] bcd(int c);
    return 8'((c / 10) * 16 + (c % 10));
  endfunction

  task automatic model_reset();
    m_fault = 0; m_phase = 0; m_rem = 0; m_ill = 0; m_leg = 0; m_win = 0;
    e_red = 1; e_yel = 0; e_grn = 0; e_pr = 1; e_pg = 0; e_valid = 0; e_fault = 0; e_cnt = 0;
  endtask

  task automatic show_run(int ph, logic [1:0] p);
    e_red = (ph == 1); e_yel = (ph == 2); e_grn = (ph == 3);
    e_pr = (p == 2'b10); e_cnt = m_rem; e_valid = 1; e_fault = 0;
`ifdef PED_FLASH_EN
    if (p == 2'b01 && m_rem >= 1 && m_rem <= PFS) begin
      e_pg = (m_win % 2) == 1;
      m_win++;
    end else begin
      e_pg = (p == 2'b01);
      m_win = 0;
    end
`else
    e_pg = (p == 2'b01);
    m_win = 0;
`endif
  endtask

  task automatic show_fault(bit first);
    e_yel = first ? 1'b1 : !e_yel;
    e_red = 0; e_grn = 0; e_pr = 1; e_pg = 0; e_cnt = 0; e_valid = 0; e_fault = 1;
    m_win = 0;
  endtask

  task automatic model_step();
    int ph;
    ph = pair_phase(traf_state, ped_state);
    if (!m_fault) begin
      if (ph != 0) begin
        m_ill = 0;
        if (ph != m_phase) begin
          m_phase = ph;
          m_rem = secs(ph);
        end else if (m_rem > 0) begin
          m_rem--;
        end
        show_run(ph, ped_state);
      end else begin
        m_ill++;
        if (m_ill == 2) begin
          m_fault = 1; m_ill = 0; m_leg = 0;
          show_fault(1);
        end
      end
    end else begin
      if (ph != 0) begin
        m_leg++;
        if (m_leg == 3) begin
          m_fault = 0; m_leg = 0; m_phase = ph; m_rem = secs(ph);
          show_run(ph, ped_state);
        end else begin
          show_fault(0);
        end
      end else begin
        m_leg = 0;
        show_fault(0);
      end
    end
  endtask

  always @(posedge clk_1Hz) if (rst_n) model_step();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_1Hz) begin
    logic [14:0] act, expv;
    if (chk_en) begin
      act  = {lamp_red, lamp_yellow, lamp_green, ped_lamp_red, ped_lamp_green,
              cnt_tens, cnt_ones, cnt_valid, fault};
      expv = {e_red, e_yel, e_grn, e_pr, e_pg, bcd(e_cnt), e_valid, e_fault};
      n_chk++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL model_cmp @%0t: got %b expected %b", $time, act, expv);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  // Apply one sample; returns after the resulting outputs are stable.
  task automatic cyc(input logic [2:0] t, input logic [1:0] p);
    traf_state = t;
    ped_state  = p;
    @(negedge clk_1Hz);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk_1Hz);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic ped_flash_exp(int c);
`ifdef PED_FLASH_EN
    return (c == 3 || c == 1) ? 1'b0 : 1'b1;
`else
    return (c >= 0) ? 1'b1 : 1'b0;
`endif
  endfunction

  initial begin
    int c, r, cur, n;
    logic [2:0] t;
    logic [1:0] p;
    rst_n = 1'b0;
    traf_state = 3'b000;
    ped_state = 2'b00;
    model_reset();
    #1 chk_en = 1'b1;
    @(negedge clk_1Hz);
    #2;
    check("rst_lamps", {lamp_red, lamp_yellow, lamp_green, ped_lamp_red, ped_lamp_green}, 5'b10010);
    check("rst_cnt", {cnt_tens, cnt_ones, cnt_valid, fault}, 10'd0);
    rst_n = 1'b1;

    // Red held 12 cycles: 10 down to 0, then stays 0.
    for (int i = 0; i < 12; i++) begin
      cyc(3'b001, 2'b01);
      c = (i <= 10) ? 10 - i : 0;
      check("red_cnt", {cnt_tens, cnt_ones}, bcd(c));
      check("red_lamp_valid", {lamp_red, lamp_green, cnt_valid}, 3'b101);
      check("red_ped_green", ped_lamp_green, ped_flash_exp(c));
    end

    cyc(3'b010, 2'b10);
    check("yel_lamps", {lamp_red, lamp_yellow, lamp_green, ped_lamp_red}, 4'b0101);
    check("yel_cnt", {cnt_tens, cnt_ones}, 8'h01);
    cyc(3'b100, 2'b10);
    check("grn_lamps", {lamp_red, lamp_yellow, lamp_green}, 3'b001);
    check("grn_cnt", {cnt_tens, cnt_ones}, 8'h10);
    cyc(3'b100, 2'b10);
    cyc(3'b100, 2'b10);
    cyc(3'b100, 2'b10);
    check("grn_cnt7", {cnt_tens, cnt_ones}, 8'h07);

    // Single glitch mid-green.
    cyc(3'b011, 2'b10);
    check("glitch_hold", {cnt_tens, cnt_ones, lamp_green, fault}, {8'h07, 2'b10});
    cyc(3'b100, 2'b10);
    check("glitch_resume", {cnt_tens, cnt_ones}, 8'h06);

    // Async reset mid-green at count 6.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_lamps", {lamp_red, lamp_yellow, lamp_green, ped_lamp_red, ped_lamp_green},
          5'b10010);
    check("midrst_cnt", {cnt_tens, cnt_ones, cnt_valid, fault}, 10'd0);
    @(negedge clk_1Hz);
    #2;
    rst_n = 1'b1;
    cyc(3'b100, 2'b10);
    check("post_rst_cnt", {cnt_tens, cnt_ones, lamp_green}, {8'h10, 1'b1});

    // Two illegal samples force FAULT.
    cyc(3'b000, 2'b00);
    check("ill1_nofault", {fault, cnt_tens, cnt_ones}, {1'b0, 8'h10});
    cyc(3'b000, 2'b00);
    check("fault_enter", {fault, lamp_yellow, cnt_valid, cnt_tens, cnt_ones}, {3'b110, 8'h00});
    check("fault_lamps", {lamp_red, lamp_green, ped_lamp_red, ped_lamp_green}, 4'b0010);
    cyc(3'b000, 2'b00);
    check("fault_blink0", {fault, lamp_yellow}, 2'b10);
    cyc(3'b000, 2'b00);
    check("fault_blink1", {fault, lamp_yellow}, 2'b11);
    cyc(3'b001, 2'b01);
    check("fault_leg1", {fault, lamp_yellow}, 2'b10);
    cyc(3'b001, 2'b01);
    check("fault_leg2", {fault, lamp_yellow}, 2'b11);
    cyc(3'b001, 2'b01);
    check("fault_exit", {fault, cnt_valid, lamp_red, cnt_tens, cnt_ones}, {3'b011, 8'h10});
    check("model_pin_cnt", e_cnt, 10);
    check("model_pin_run", {m_fault, e_valid}, 2'b01);

    // Illegal sample in FAULT restarts the legal count.
    cyc(3'b111, 2'b11);
    cyc(3'b111, 2'b11);
    cyc(3'b100, 2'b10);
    cyc(3'b100, 2'b10);
    cyc(3'b110, 2'b00);
    cyc(3'b100, 2'b10);
    cyc(3'b100, 2'b10);
    check("restart_still_fault", fault, 1'b1);
    cyc(3'b100, 2'b10);
    check("restart_exit", {fault, lamp_green, cnt_tens, cnt_ones}, {2'b01, 8'h10});

    // Randomized traffic checked every cycle by the model.
    cur = 3;
    for (int k = 0; k < 700; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        pulse_reset();
      end else if (r < 5) begin
        n = $urandom_range(2, 5);
        for (int j = 0; j < n; j++) begin
          do begin
            t = 3'($urandom_range(0, 7));
            p = 2'($urandom_range(0, 3));
          end while (pair_phase(t, p) != 0);
          cyc(t, p);
        end
      end else if (r < 10) begin
        do begin
          t = 3'($urandom_range(0, 7));
          p = 2'($urandom_range(0, 3));
        end while (pair_phase(t, p) != 0);
        cyc(t, p);
      end else begin
        if (r < 16) cur = $urandom_range(1, 3);
        case (cur)
          1:       cyc(3'b001, 2'b01);
          2:       cyc(3'b010, 2'b10);
          default: cyc(3'b100, 2'b10);
        endcase
      end
    end

    @(negedge clk_1Hz);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
